// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Central pipeline sequencer for the 5-stage RV32 core. Turns
//            hazard stall/flush requests, data-memory wait and MDU busy into
//            per-stage register enables and bubble controls.
//            Optional macro PIPE_CTRL_PERF_EN adds stall/flush perf counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl #(
    parameter int REFILL_CYCLES = 1,
    parameter int CNT_W         = 4
`ifdef PIPE_CTRL_PERF_EN
    ,
    parameter int PERF_W        = 32
`endif
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             stall_in,
    input  logic             flush_in,
    input  logic             dmem_req_in,
    input  logic             dmem_ready_in,
    input  logic             mdu_start_in,
    input  logic             mdu_done_in,
    output logic             pc_en_out,
    output logic             ifid_en_out,
    output logic             ifid_flush_out,
    output logic             idex_en_out,
    output logic             idex_flush_out,
    output logic             exmem_en_out,
    output logic             exmem_flush_out,
    output logic             memwb_en_out,
    output logic             memwb_flush_out,
    output logic [1:0]       state_out
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cycles_out,
    output logic [PERF_W-1:0] flush_count_out
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        MWAIT = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_REFILL = CNT_W'(REFILL_CYCLES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic w_dmem_stall;
    logic w_mdu_stall;

    assign w_dmem_stall = dmem_req_in & ~dmem_ready_in;
    assign w_mdu_stall  = mdu_start_in & ~mdu_done_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pc_en_out       = 1'b1;
        ifid_en_out     = 1'b1;
        ifid_flush_out  = 1'b0;
        idex_en_out     = 1'b1;
        idex_flush_out  = 1'b0;
        exmem_en_out    = 1'b1;
        exmem_flush_out = 1'b0;
        memwb_en_out    = 1'b1;
        memwb_flush_out = 1'b0;
        state_out       = state_q;

        unique case (state_q)
            RUN: begin
                if (w_dmem_stall) begin
                    {pc_en_out, ifid_en_out, idex_en_out, exmem_en_out} = 4'b0000;
                    memwb_flush_out = 1'b1;
                    state_d         = DWAIT;
                end else if (w_mdu_stall) begin
                    {pc_en_out, ifid_en_out, idex_en_out} = 3'b000;
                    exmem_flush_out = 1'b1;
                    state_d         = MWAIT;
                end else if (flush_in) begin
                    // flush outranks stall: the stalled instruction is squashed
                    ifid_flush_out = 1'b1;
                    idex_flush_out = 1'b1;
                    cnt_d          = C_REFILL;
                    state_d        = (REFILL_CYCLES > 0) ? DRAIN : RUN;
                end else if (stall_in) begin
                    pc_en_out      = 1'b0;
                    ifid_en_out    = 1'b0;
                    idex_flush_out = 1'b1;
                end
            end
            DWAIT: begin
                if (w_dmem_stall) begin
                    {pc_en_out, ifid_en_out, idex_en_out, exmem_en_out} = 4'b0000;
                    memwb_flush_out = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            MWAIT: begin
                if (!mdu_done_in) begin
                    {pc_en_out, ifid_en_out, idex_en_out} = 3'b000;
                    if (w_dmem_stall) begin
                        exmem_en_out    = 1'b0;
                        memwb_flush_out = 1'b1;
                    end else begin
                        exmem_flush_out = 1'b1;
                    end
                end else if (w_dmem_stall) begin
                    // MDU finishes while memory still waits: memory freeze wins
                    {pc_en_out, ifid_en_out, idex_en_out, exmem_en_out} = 4'b0000;
                    memwb_flush_out = 1'b1;
                    state_d         = DWAIT;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (w_dmem_stall) begin
                    {pc_en_out, ifid_en_out, idex_en_out, exmem_en_out} = 4'b0000;
                    memwb_flush_out = 1'b1;
                    cnt_d           = '0;
                    state_d         = DWAIT;
                end else begin
                    ifid_flush_out = 1'b1;
                    if (flush_in) begin
                        cnt_d = C_REFILL;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = RUN;
                        end
                    end
                end
            end
            default: state_d = RUN;
        endcase

        if (rst_in) begin
            {pc_en_out, ifid_en_out, idex_en_out, exmem_en_out, memwb_en_out} = 5'b00000;
            {ifid_flush_out, idex_flush_out, exmem_flush_out, memwb_flush_out} = 4'b1111;
            state_out = RUN;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic              w_flush_acc;
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] flush_cnt_q;

    assign w_flush_acc = flush_in & ~w_dmem_stall &
                         (((state_q == RUN) & ~w_mdu_stall) | (state_q == DRAIN));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_en_out)  stall_cnt_q <= stall_cnt_q + 1'b1;
            if (w_flush_acc) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cycles_out = stall_cnt_q;
    assign flush_count_out  = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage RV32 core. It turns hazard-unit stall/flush requests, data-memory wait and multi-cycle MDU (mul/div) busy into per-stage register enables and bubble (flush) controls. It replaces ad-hoc gating at each pipeline register with one prioritized FSM.

Parameters:
REFILL_CYCLES, 1, extra cycles IF/ID is held flushed after a redirect while the instruction memory refetches (0..15)
CNT_W, 4, width of refill counter
PERF_W, 32, width of performance counters (optional feature only)

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  synchronous active-high reset
stall_in  input  1  load-use stall request from hazard unit
flush_in  input  1  branch/jump mispredict from hazard unit
dmem_req_in  input  1  MEM-stage load/store active
dmem_ready_in  input  1  data memory completes access this cycle
mdu_start_in  input  1  EX-stage instruction is a multi-cycle MDU op
mdu_done_in  input  1  MDU result valid this cycle
pc_en_out  output  1  PC register load enable
ifid_en_out  output  1  IF/ID enable
ifid_flush_out  output  1  IF/ID load bubble
idex_en_out  output  1  ID/EX enable
idex_flush_out  output  1  ID/EX load bubble
exmem_en_out  output  1  EX/MEM enable
exmem_flush_out  output  1  EX/MEM load bubble
memwb_en_out  output  1  MEM/WB enable
memwb_flush_out  output  1  MEM/WB load bubble
state_out  output  2  current FSM state (debug)

Behaviour:
- One clock; synchronous active-high reset on clk_in/rst_in. Flush has priority over enable at each register.
- States: RUN=0, DWAIT=1, MWAIT=2, DRAIN=3. Reset -> RUN, refill counter=0.
- While rst_in=1: all *_en_out=0, all *_flush_out=1, state_out=0.
- Outputs combinational from state + inputs; state/counter registered.
- Default (RUN, no events): all enables 1, all flushes 0.
- RUN priority, highest first:
  1. dmem_req_in & !dmem_ready_in: pc/ifid/idex/exmem enables 0; memwb_flush_out=1; next DWAIT.
  2. mdu_start_in & !mdu_done_in: pc/ifid/idex enables 0; exmem_flush_out=1; next MWAIT.
  3. flush_in: all enables 1; ifid_flush_out=1, idex_flush_out=1; next DRAIN if REFILL_CYCLES>0 (counter loads REFILL_CYCLES), else RUN.
  4. stall_in: pc_en_out=0, ifid_en_out=0, idex_flush_out=1; stays RUN.
  flush_in overrides stall_in the same cycle (stalled instruction is squashed).
- DWAIT: same freeze as RUN rule 1 until dmem_ready_in=1; that cycle gives default outputs (zero extra latency) and next RUN. flush_in/stall_in/mdu_start_in ignored (EX frozen, reasserted after release).
- MWAIT: same freeze as RUN rule 2 until mdu_done_in=1; that cycle gives default outputs, next RUN. If dmem_req_in & !dmem_ready_in in MWAIT: additionally exmem_en_out=0, memwb_flush_out=1 (exmem_flush_out=0); stay MWAIT.
- DRAIN: pc_en_out=1, ifid_flush_out=1, others default; counter decrements each cycle; at counter==1, next RUN. Stall in DRAIN: dmem condition -> DWAIT (counter discarded); flush_in reloads counter; stall_in and mdu_start_in ignored (ID/EX hold bubbles).
- mdu_start_in & mdu_done_in same cycle in RUN: no stall.
- Reset mid-state: immediate return to RUN next cycle, counter cleared.

Optional Feature:
Macro PIPE_CTRL_PERF_EN. When defined: adds outputs stall_cycles_out [PERF_W] (increments each cycle any of pc_en_out=0 outside reset) and flush_count_out [PERF_W] (increments per accepted flush_in); both cleared by rst_in, wrap at 2^PERF_W. When undefined: ports and counters absent; rest identical.

Test Plan:
- Reset 3 cycles then release, no inputs -> during reset all flushes 1/enables 0; cycle after release all enables 1, state_out=0.
- stall_in=1 one cycle in RUN -> that cycle pc_en_out=0, ifid_en_out=0, idex_flush_out=1; next cycle defaults, state_out=0.
- dmem_req_in=1, dmem_ready_in=0 for 3 cycles then 1 -> 3 cycles frozen with memwb_flush_out=1, state_out=1; ready cycle all enables 1; then state_out=0.
- mdu_start_in=1 held, mdu_done_in after 5 cycles -> exmem_flush_out=1 for 5 cycles, state_out=2; done cycle defaults.
- REFILL_CYCLES=2, flush_in=1 with stall_in=1 -> ifid/idex flush, pc_en_out=1; then 2 DRAIN cycles ifid_flush_out=1, state_out=3; then RUN.
- PIPE_CTRL_PERF_EN defined, run scenarios 2-5 -> stall_cycles_out=9, flush_count_out=1.
